// File: rtl/hazard5_bus_arbiter_pkg.sv
// rtl/hazard5_bus_arbiter_pkg.sv - shared AHB-Lite encodings and owner tags for the bus arbiter
package hazard5_bus_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/hazard5_bus_arbiter.sv
// rtl/hazard5_bus_arbiter.sv - shares one AHB-Lite master port between fetch (I) and load/store (D)
module hazard5_bus_arbiter
  import hazard5_bus_arbiter_pkg::*;
#(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int W_STARVE     = 3
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_req,
  input  logic [W_ADDR-1:0] i_addr,
  input  logic [2:0]        i_size,
  output logic              i_aph_rdy,
  output logic              i_dph_rdy,
  output logic              i_dph_err,

  input  logic              d_req,
  input  logic [W_ADDR-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic              d_write,
  input  logic [W_DATA-1:0] d_wdata,
  output logic              d_aph_rdy,
  output logic              d_dph_rdy,
  output logic              d_dph_err,

  output logic [W_DATA-1:0] rdata,

  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [W_DATA-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [W_DATA-1:0] hrdata
);

  localparam logic [W_STARVE-1:0] STARVE_LIMIT_W = W_STARVE'(STARVE_LIMIT);

  owner_t              aph_grant;
  owner_t              hold_owner;
  owner_t              dph_owner;
  logic [W_STARVE-1:0] starve_cnt;
  logic [W_DATA-1:0]   hwdata_r;
  logic                i_starved;

  assign i_starved = (STARVE_LIMIT != 0) && (starve_cnt >= STARVE_LIMIT_W);

  // A stalled address phase keeps its owner; the first error cycle must present IDLE.
  always_comb begin
    aph_grant = OWNER_NONE;
    if (hold_owner != OWNER_NONE)
      aph_grant = hold_owner;
    else if (hresp && !hready)
      aph_grant = OWNER_NONE;
    else if (d_req && !(i_req && i_starved))
      aph_grant = OWNER_D;
    else if (i_req)
      aph_grant = OWNER_I;
  end

  always_comb begin
    htrans = HTRANS_IDLE;
    haddr  = '0;
    hsize  = '0;
    hwrite = 1'b0;
    case (aph_grant)
      OWNER_I: begin
        htrans = HTRANS_NONSEQ;
        haddr  = i_addr;
        hsize  = i_size;
      end
      OWNER_D: begin
        htrans = HTRANS_NONSEQ;
        haddr  = d_addr;
        hsize  = d_size;
        hwrite = d_write;
      end
      default: ;
    endcase
  end

  assign i_aph_rdy = hready && (aph_grant == OWNER_I);
  assign d_aph_rdy = hready && (aph_grant == OWNER_D);
  assign i_dph_rdy = hready && (dph_owner == OWNER_I);
  assign d_dph_rdy = hready && (dph_owner == OWNER_D);
  assign i_dph_err = hready && hresp && (dph_owner == OWNER_I);
  assign d_dph_err = hready && hresp && (dph_owner == OWNER_D);

  assign rdata  = hrdata;
  assign hwdata = hwdata_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_owner <= OWNER_NONE;
      dph_owner  <= OWNER_NONE;
      hwdata_r   <= '0;
    end else begin
      hold_owner <= (htrans == HTRANS_NONSEQ && !hready) ? aph_grant : OWNER_NONE;
      if (hready)
        dph_owner <= aph_grant;
      if (d_aph_rdy && d_write)
        hwdata_r <= d_wdata;
    end
  end

  // Counts consecutive address phases fetch lost to load/store while it was waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (i_aph_rdy || !i_req) begin
      starve_cnt <= '0;
    end else if (hready && aph_grant == OWNER_D && starve_cnt != '1) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard5_bus_arbiter.sv
// tb/tb_hazard5_bus_arbiter.sv - directed and randomized checks of hazard5_bus_arbiter
module tb_hazard5_bus_arbiter;
  import hazard5_bus_arbiter_pkg::*;

  localparam int LIMIT = 3;
  localparam int WS    = 3;
  localparam int SAT   = (1 << WS) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_write, hready, hresp;
  logic [31:0] i_addr, d_addr, d_wdata, hrdata;
  logic [2:0]  i_size, d_size;
  logic        i_aph_rdy, i_dph_rdy, i_dph_err, d_aph_rdy, d_dph_rdy, d_dph_err, hwrite;
  logic [31:0] rdata, haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [5:0]  rv;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rv = {i_aph_rdy, i_dph_rdy, i_dph_err, d_aph_rdy, d_dph_rdy, d_dph_err};

  hazard5_bus_arbiter #(
    .W_ADDR(32), .W_DATA(32), .STARVE_LIMIT(LIMIT), .W_STARVE(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_size(i_size),
    .i_aph_rdy(i_aph_rdy), .i_dph_rdy(i_dph_rdy), .i_dph_err(i_dph_err),
    .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_write(d_write), .d_wdata(d_wdata),
    .d_aph_rdy(d_aph_rdy), .d_dph_rdy(d_dph_rdy), .d_dph_err(d_dph_err),
    .rdata(rdata), .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
    .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    checks++; if (htrans !== HTRANS_IDLE) begin errors++; $display("FAIL reset_htrans got=%0h exp=0", htrans); end
    checks++; if ({haddr, hwrite, hsize} !== '0) begin errors++; $display("FAIL reset_addr got=%0h/%0b/%0h exp=0", haddr, hwrite, hsize); end
    checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata got=%0h exp=0", hwdata); end
    checks++; if (rv !== 6'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=000000", rv); end
    rst_n = 1'b1;
    cyc();
    checks++; if (htrans !== HTRANS_IDLE || rv !== 6'b0) begin errors++; $display("FAIL idle_after_reset got=%0h/%b exp=0/000000", htrans, rv); end
  endtask

  task automatic test_d_read();
    logic [31:0] val;
    val = $urandom;
    cyc();
    d_req = 1'b1; d_addr = 32'h100; d_size = HSIZE_WORD; d_write = 1'b0;
    #1;
    checks++; if (htrans !== HTRANS_NONSEQ || haddr !== 32'h100) begin errors++; $display("FAIL d_read_aph got=%0h/%0h exp=2/100", htrans, haddr); end
    checks++; if (rv !== 6'b000100) begin errors++; $display("FAIL d_read_aph_rdy got=%b exp=000100", rv); end
    cyc();
    d_req = 1'b0; hrdata = val;
    #1;
    checks++; if (rv !== 6'b000010) begin errors++; $display("FAIL d_read_dph got=%b exp=000010", rv); end
    checks++; if (rdata !== val) begin errors++; $display("FAIL d_read_rdata got=%0h exp=%0h", rdata, val); end
    checks++; if (htrans !== HTRANS_IDLE) begin errors++; $display("FAIL d_read_idle got=%0h exp=0", htrans); end
    cyc();
    checks++; if (rv !== 6'b0) begin errors++; $display("FAIL d_read_done got=%b exp=000000", rv); end
  endtask

  task automatic test_contention();
    cyc();
    i_req = 1'b1; i_addr = 32'h0; i_size = HSIZE_WORD;
    d_req = 1'b1; d_addr = 32'h200; d_size = HSIZE_WORD; d_write = 1'b0;
    #1;
    checks++; if (haddr !== 32'h200 || rv !== 6'b000100) begin errors++; $display("FAIL contend_c0 got=%0h/%b exp=200/000100", haddr, rv); end
    cyc();
    d_req = 1'b0;
    #1;
    checks++; if (haddr !== 32'h0 || htrans !== HTRANS_NONSEQ || rv !== 6'b100010) begin errors++; $display("FAIL contend_c1 got=%0h/%0h/%b exp=0/2/100010", haddr, htrans, rv); end
    cyc();
    i_req = 1'b0;
    #1;
    checks++; if (htrans !== HTRANS_IDLE || rv !== 6'b010000) begin errors++; $display("FAIL contend_c2 got=%0h/%b exp=0/010000", htrans, rv); end
    cyc();
  endtask

  task automatic test_starvation();
    cyc();
    i_req = 1'b1; i_addr = 32'h1000; i_size = HSIZE_WORD;
    d_req = 1'b1; d_addr = 32'h400; d_size = HSIZE_WORD; d_write = 1'b0; hready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k == 3) begin
        checks++; if (haddr !== 32'h1000 || rv[5] !== 1'b1 || rv[2] !== 1'b0) begin errors++; $display("FAIL starve_k%0d got=%0h/%b exp=1000/I", k, haddr, rv); end
      end else begin
        checks++; if (haddr !== d_addr || rv[2] !== 1'b1 || rv[5] !== 1'b0) begin errors++; $display("FAIL starve_k%0d got=%0h/%b exp=%0h/D", k, haddr, rv, d_addr); end
      end
      cyc();
      if (k < 3) d_addr = d_addr + 32'h4;
      if (k == 3) i_req = 1'b0;
    end
    d_req = 1'b0;
    cyc();
  endtask

  task automatic test_wait_states();
    cyc();
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h300; d_size = HSIZE_WORD; d_wdata = 32'hDEADBEEF; hready = 1'b0;
    #1;
    checks++; if (htrans !== HTRANS_NONSEQ || haddr !== 32'h300 || hwrite !== 1'b1 || rv !== 6'b0) begin errors++; $display("FAIL wait_c0 got=%0h/%0h/%b/%b exp=2/300/1/000000", htrans, haddr, hwrite, rv); end
    cyc();
    i_req = 1'b1; i_addr = 32'h40; i_size = HSIZE_WORD;
    #1;
    checks++; if (htrans !== HTRANS_NONSEQ || haddr !== 32'h300 || rv !== 6'b0) begin errors++; $display("FAIL wait_c1_hold got=%0h/%0h/%b exp=2/300/000000", htrans, haddr, rv); end
    cyc();
    hready = 1'b1;
    #1;
    checks++; if (haddr !== 32'h300 || rv !== 6'b000100) begin errors++; $display("FAIL wait_c2 got=%0h/%b exp=300/000100", haddr, rv); end
    cyc();
    d_req = 1'b0; d_write = 1'b0; hready = 1'b0;
    #1;
    checks++; if (haddr !== 32'h40 || hwdata !== 32'hDEADBEEF || rv !== 6'b0) begin errors++; $display("FAIL wait_c3 got=%0h/%0h/%b exp=40/deadbeef/000000", haddr, hwdata, rv); end
    cyc();
    hready = 1'b1;
    #1;
    checks++; if (haddr !== 32'h40 || hwdata !== 32'hDEADBEEF || rv !== 6'b100010) begin errors++; $display("FAIL wait_c4 got=%0h/%0h/%b exp=40/deadbeef/100010", haddr, hwdata, rv); end
    cyc();
    i_req = 1'b0;
    #1;
    checks++; if (rv !== 6'b010000) begin errors++; $display("FAIL wait_c5 got=%b exp=010000", rv); end
    cyc();
  endtask

  task automatic test_error();
    cyc();
    i_req = 1'b1; i_addr = 32'h80; i_size = HSIZE_WORD; hready = 1'b1; hresp = 1'b0;
    #1;
    checks++; if (rv !== 6'b100000) begin errors++; $display("FAIL err_c0 got=%b exp=100000", rv); end
    cyc();
    i_req = 1'b0; d_req = 1'b1; d_addr = 32'h500; d_write = 1'b0; hresp = 1'b1; hready = 1'b0;
    #1;
    checks++; if (htrans !== HTRANS_IDLE || rv !== 6'b0) begin errors++; $display("FAIL err_c1 got=%0h/%b exp=0/000000", htrans, rv); end
    cyc();
    hready = 1'b1;
    #1;
    checks++; if (htrans !== HTRANS_NONSEQ || haddr !== 32'h500 || rv !== 6'b011100) begin errors++; $display("FAIL err_c2 got=%0h/%0h/%b exp=2/500/011100", htrans, haddr, rv); end
    cyc();
    d_req = 1'b0; hresp = 1'b0;
    #1;
    checks++; if (rv !== 6'b000010) begin errors++; $display("FAIL err_c3 got=%b exp=000010", rv); end
    cyc();
  endtask

  task automatic test_reset_mid();
    cyc();
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h600; d_wdata = 32'h12345678; hready = 1'b1;
    #1;
    checks++; if (rv !== 6'b000100) begin errors++; $display("FAIL rstmid_aph got=%b exp=000100", rv); end
    cyc();
    d_req = 1'b0; d_write = 1'b0; hready = 1'b0;
    #1;
    checks++; if (hwdata !== 32'h12345678 || rv !== 6'b0) begin errors++; $display("FAIL rstmid_wait got=%0h/%b exp=12345678/000000", hwdata, rv); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (hwdata !== 32'h0 || htrans !== HTRANS_IDLE || haddr !== 32'h0 || rv !== 6'b0) begin errors++; $display("FAIL rstmid_async got=%0h/%0h/%0h/%b exp=0/0/0/000000", hwdata, htrans, haddr, rv); end
    hready = 1'b1;
    #1;
    checks++; if (rv !== 6'b0) begin errors++; $display("FAIL rstmid_no_dph got=%b exp=000000", rv); end
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
    checks++; if (rv !== 6'b0) begin errors++; $display("FAIL rstmid_release got=%b exp=000000", rv); end
    cyc();
    checks++; if (rv !== 6'b0 || htrans !== HTRANS_IDLE) begin errors++; $display("FAIL rstmid_after got=%b/%0h exp=000000/0", rv, htrans); end
  endtask

  // Reference: arbitration rules evaluated each cycle on bench-held transaction state.
  task automatic test_back_to_back_random();
    owner_t      lock_by = OWNER_NONE;
    owner_t      in_dph  = OWNER_NONE;
    owner_t      g;
    int          lost    = 0;
    logic [31:0] wbuf    = 32'h0;
    logic        err2    = 1'b0;
    logic        i_acc   = 1'b0;
    logic        d_acc   = 1'b0;
    logic [31:0] e_addr;
    logic [2:0]  e_size;
    logic        e_write;
    logic [5:0]  e_rv;
    for (int n = 0; n < 600; n++) begin
      cyc();
      if (i_acc) i_req = 1'b0;
      if (d_acc) d_req = 1'b0;
      if (!i_req && $urandom_range(0, 2) != 0) begin
        i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC; i_size = HSIZE_WORD;
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1; d_addr = $urandom; d_size = 3'($urandom_range(0, 2));
        d_write = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      hrdata = $urandom;
      if (err2) begin
        hresp = 1'b1; hready = 1'b1; err2 = 1'b0;
      end else if (in_dph != OWNER_NONE && $urandom_range(0, 9) == 0) begin
        hresp = 1'b1; hready = 1'b0; err2 = 1'b1;
      end else begin
        hresp = 1'b0; hready = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (lock_by != OWNER_NONE)                    g = lock_by;
      else if (hresp && !hready)                    g = OWNER_NONE;
      else if (d_req && !(i_req && lost >= LIMIT))  g = OWNER_D;
      else if (i_req)                               g = OWNER_I;
      else                                          g = OWNER_NONE;
      e_addr  = (g == OWNER_D) ? d_addr : (g == OWNER_I) ? i_addr : 32'h0;
      e_size  = (g == OWNER_D) ? d_size : (g == OWNER_I) ? i_size : 3'h0;
      e_write = (g == OWNER_D) && d_write;
      e_rv = {hready && g == OWNER_I, hready && in_dph == OWNER_I, hready && hresp && in_dph == OWNER_I,
              hready && g == OWNER_D, hready && in_dph == OWNER_D, hready && hresp && in_dph == OWNER_D};
      checks++; if (htrans !== ((g != OWNER_NONE) ? HTRANS_NONSEQ : HTRANS_IDLE)) begin errors++; $display("FAIL rand%0d htrans got=%0h grant=%0d", n, htrans, g); end
      checks++; if ({haddr, hsize, hwrite} !== {e_addr, e_size, e_write}) begin errors++; $display("FAIL rand%0d addr got=%0h/%0h/%b exp=%0h/%0h/%b", n, haddr, hsize, hwrite, e_addr, e_size, e_write); end
      checks++; if (rv !== e_rv) begin errors++; $display("FAIL rand%0d rdy got=%b exp=%b", n, rv, e_rv); end
      checks++; if (hwdata !== wbuf || rdata !== hrdata) begin errors++; $display("FAIL rand%0d data got=%0h/%0h exp=%0h/%0h", n, hwdata, rdata, wbuf, hrdata); end
      i_acc = hready && g == OWNER_I;
      d_acc = hready && g == OWNER_D;
      lock_by = (g != OWNER_NONE && !hready) ? g : OWNER_NONE;
      if (hready) in_dph = g;
      if (d_acc && d_write) wbuf = d_wdata;
      if (!i_req || i_acc) lost = 0;
      else if (d_acc && lost < SAT) lost = lost + 1;
    end
    cyc();
    i_req = 1'b0; d_req = 1'b0; hready = 1'b1; hresp = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0; i_size = '0;
    d_req = 1'b0; d_addr = '0; d_size = '0; d_write = 1'b0; d_wdata = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    test_reset();
    test_d_read();
    test_contention();
    test_starvation();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
